qspi_ram_responder: RTL and testbench
=====================================

// Module: qspi_ram_responder
// PURPOSE
//  Quad-SPI RAM responder: the memory side of the QSPI bus driven by the tinyQV core.
//  Emulates a byte-addressed quad RAM from an internal array, for FPGA builds and benches
//  with no external PSRAM. Oversamples the bus with the system clock, so all logic is on clk.
// PARAMETERS
//  ADDR_BITS  16  byte address width; array holds 2**ADDR_BITS bytes
//  DUMMY      4   sck cycles between last address nibble and first read data nibble
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous active-low reset
//  spi_clk_in    in   1  bus SCK from initiator
//  spi_cs_n      in   1  bus chip select, active low
//  spi_data_in   in   4  bus data sd[3:0] as seen at the pads
//  spi_data_out  out  4  read data nibble to drive onto sd[3:0]
//  spi_data_oe   out  4  per-bit output enable for sd[3:0], all bits equal
//  busy          out  1  high while a transaction is selected (cs low, synchronised)
// BEHAVIOUR
//  Reset: spi_data_out=0, spi_data_oe=0, busy=0, state IDLE. Array contents not reset.
//  Reset mid-transaction is an immediate abort.
//  Sync: spi_clk_in, spi_cs_n and spi_data_in each pass through 2 flops. sck edges are
//    detected from the synchronised copy. Bus rule: sck high and low phases >= 3 clk each.
//  Sampling: on each detected sck rise, the synchronised data nibble is taken.
//  Output: spi_data_out/oe update on the clk after a detected sck fall, and change only there.
//  Bit order: all transfers are 4-bit quad, high nibble first.
//  States:
//   IDLE   cs_n high, oe=0. Synced cs_n falling -> CMD; clear nibble counter.
//   CMD    2 nibbles form cmd byte.
//          0xEB -> ADDR(read). 0x38 -> ADDR(write). Any other -> IGNORE.
//   ADDR   6 nibbles = 24-bit address; low ADDR_BITS kept, upper bits ignored.
//          -> DUMMY (read) or WRITE.
//   DUMMY  DUMMY sck rises ignored, oe=0. On the fall after the last dummy rise:
//          oe=4'hF, out = high nibble of mem[addr] -> READ.
//          DUMMY=0: that first drive happens on the fall after the last address rise.
//   READ   Each fall drives the next nibble: low nibble, then the next byte's high nibble, ...
//          addr increments after each low nibble is driven.
//   WRITE  Nibble pairs assemble a byte. On the 2nd rise mem[addr] <= byte, addr++.
//          A lone trailing high nibble at cs_n rise is discarded.
//   IGNORE oe=0; bus ignored until cs_n rises.
//  Any state: synced cs_n high -> IDLE within 1 clk, oe=0, partial byte dropped.
//  Address wrap: addr at 2**ADDR_BITS-1 increments to 0 (modulo array size).
//  busy = ~synced cs_n, registered.
//  sck edges while cs_n is high are ignored.
//  Read of the byte written in the same transaction is not possible (single direction per cs).
//  Read-after-write across transactions returns the new data.
// TESTING
//  1 Reset: hold rst_n=0, toggle sck/cs -> oe=0, out=0, busy=0 throughout.
//  2 Write/read back:
//      cs low, 0x38, addr 0x000010, bytes A5 3C 0F; cs high.
//      cs low, 0xEB, addr 0x000010, 4 dummy, read 3 bytes -> A5 3C 0F.
//      oe=F only during data phase.
//  3 Wrap at ADDR_BITS=16:
//      write 11 22 at addr 0x00FFFF -> mem[FFFF]=11, mem[0000]=22.
//      Read from FFFF -> 11 22.
//  4 Abort:
//      raise cs after 1 nibble of a write byte at addr 0x20 -> mem[0x20] unchanged.
//      Raise cs mid-read -> oe=0 within 3 clk, next cs low starts in CMD.
//  5 Bad command 0x9F + 8 nibbles -> oe stays 0, no array write, next transaction works.
//  6 Timing: sck 3 clk high / 3 clk low -> out stable from fall+3 clk through the next rise.
//    Upper address bits 0xFF0010 alias to 0x0010.

Source files
------------

// File: rtl/qspi_ram_responder.sv
// Quad-SPI RAM responder: oversamples the initiator's SCK/CS/data on clk and serves
// 0xEB quad reads and 0x38 quad writes from an internal byte array.
module qspi_ram_responder #(
  parameter int ADDR_BITS = 16,
  parameter int DUMMY     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk_in,
  input  logic       spi_cs_n,
  input  logic [3:0] spi_data_in,
  output logic [3:0] spi_data_out,
  output logic [3:0] spi_data_oe,
  output logic       busy
);
  // state   | meaning
  // IDLE    | cs_n high, waiting for a synced cs_n fall
  // CMD     | collecting the two command nibbles
  // ADDR    | collecting six address nibbles
  // DUMMY   | counting dummy sck rises before read data
  // READ    | driving a nibble on every sck fall
  // WRITE   | assembling nibble pairs into array writes
  // IGNORE  | unknown command, wait for cs_n high

  localparam int CNT_MAX = (DUMMY > 5) ? DUMMY : 5;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [7:0] CMD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
  } state_t;

  state_t r_state, w_next;

  logic [1:0]           r_sck_s, r_cs_s;
  logic [3:0]           r_d_s0, r_d_s1;
  logic                 r_sck_d, r_cs_d;
  logic [3:0]           r_cmd_hi;
  logic                 r_is_read;
  logic [ADDR_BITS-1:0] r_addr;
  logic [CW-1:0]        r_cnt;
  logic                 r_lo_next;
  logic [3:0]           r_wr_hi;
  logic                 r_have_hi;
  logic [3:0]           r_out;
  logic                 r_oe;
  logic                 r_busy;
  logic [7:0]           r_mem [2**ADDR_BITS];

  logic       w_sck, w_cs_n, w_rise, w_fall, w_cs_fall, w_mem_we;
  logic [3:0] w_nib;
  logic [7:0] w_cmd, w_rd_byte;

  assign w_sck     = r_sck_s[1];
  assign w_cs_n    = r_cs_s[1];
  assign w_nib     = r_d_s1;
  assign w_rise    = ~w_cs_n & w_sck & ~r_sck_d;
  assign w_fall    = ~w_cs_n & ~w_sck & r_sck_d;
  assign w_cs_fall = r_cs_d & ~w_cs_n;
  assign w_cmd     = {r_cmd_hi, w_nib};
  assign w_rd_byte = r_mem[r_addr];
  assign w_mem_we  = (r_state == S_WRITE) && w_rise && r_have_hi;

  assign spi_data_out = r_out;
  assign spi_data_oe  = {4{r_oe}};
  assign busy         = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s <= 2'b00;
      r_cs_s  <= 2'b11;
      r_d_s0  <= 4'h0;
      r_d_s1  <= 4'h0;
      r_sck_d <= 1'b0;
      r_cs_d  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_sck_s <= {r_sck_s[0], spi_clk_in};
      r_cs_s  <= {r_cs_s[0], spi_cs_n};
      r_d_s0  <= spi_data_in;
      r_d_s1  <= r_d_s0;
      r_sck_d <= w_sck;
      r_cs_d  <= w_cs_n;
      r_busy  <= ~w_cs_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_cs_n) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_next = S_CMD;
        S_CMD:   if (w_rise && r_cnt == '0)
                   w_next = (w_cmd == CMD_READ || w_cmd == CMD_WRITE) ? S_ADDR : S_IGNORE;
        S_ADDR:  if (w_rise && r_cnt == '0) w_next = r_is_read ? S_DUMMY : S_WRITE;
        S_DUMMY: if (w_fall && r_cnt == '0) w_next = S_READ;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_hi  <= 4'h0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_lo_next <= 1'b0;
      r_wr_hi   <= 4'h0;
      r_have_hi <= 1'b0;
      r_out     <= 4'h0;
      r_oe      <= 1'b0;
    end else if (w_cs_n) begin
      r_oe      <= 1'b0;
      r_have_hi <= 1'b0;
      r_cnt     <= CW'(1);
    end else begin
      case (r_state)
        S_IDLE: r_cnt <= CW'(1);
        S_CMD: if (w_rise) begin
          if (r_cnt == '0) begin
            r_is_read <= (w_cmd == CMD_READ);
            r_cnt     <= CW'(5);
          end else begin
            r_cmd_hi <= w_nib;
            r_cnt    <= r_cnt - 1'b1;
          end
        end
        S_ADDR: if (w_rise) begin
          // shifting through a narrow register keeps only the low ADDR_BITS
          r_addr <= {r_addr[ADDR_BITS-5:0], w_nib};
          r_cnt  <= (r_cnt == '0) ? CW'(DUMMY) : r_cnt - 1'b1;
        end
        S_DUMMY: begin
          if (w_rise && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          if (w_fall && r_cnt == '0) begin
            r_out     <= w_rd_byte[7:4];
            r_oe      <= 1'b1;
            r_lo_next <= 1'b1;
          end
        end
        S_READ: if (w_fall) begin
          if (r_lo_next) begin
            r_out  <= w_rd_byte[3:0];
            r_addr <= r_addr + 1'b1;
          end else begin
            r_out <= w_rd_byte[7:4];
          end
          r_lo_next <= ~r_lo_next;
        end
        S_WRITE: if (w_rise) begin
          if (r_have_hi) begin
            r_addr    <= r_addr + 1'b1;
            r_have_hi <= 1'b0;
          end else begin
            r_wr_hi   <= w_nib;
            r_have_hi <= 1'b1;
          end
        end
        default: r_oe <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= {r_wr_hi, w_nib};
  end

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Bench for qspi_ram_responder: drives QSPI transactions as an initiator and checks
// the responder against a byte-array model of the RAM.
module tb_qspi_ram_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] sd = 4'h0;
  logic [3:0] dout, doe;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int H = 4;
  int L = 4;

  logic       win = 1'b0;
  logic       e_oe = 1'b0;
  logic [3:0] e_out = 4'h0;
  logic [3:0] cap_nib = 4'h0;

  logic [7:0] m_mem [0:65535];
  typedef logic [7:0] bq_t [$];
  bq_t got;
  bq_t wq;

  qspi_ram_responder #(.ADDR_BITS(16), .DUMMY(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_clk_in   (sck),
    .spi_cs_n     (cs_n),
    .spi_data_in  (sd),
    .spi_data_out (dout),
    .spi_data_oe  (doe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // While the initiator holds sck high, the responder's outputs must be settled.
  always @(negedge clk) begin
    if (win) begin
      chk("busy_in_txn", {31'b0, busy}, 32'h1);
      chk("oe", {28'b0, doe}, e_oe ? 32'hF : 32'h0);
      if (e_oe) chk("out", {28'b0, dout}, {28'b0, e_out});
    end
  end

  task automatic nib(input logic [3:0] d, input logic eoe, input logic [3:0] eout);
    sd = d;
    repeat (L) @(negedge clk);
    e_oe  = eoe;
    e_out = eout;
    win   = 1'b1;
    cap_nib = dout;
    sck = 1'b1;
    repeat (H) @(negedge clk);
    sck = 1'b0;
    win = 1'b0;
  endtask

  task automatic start_txn();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_start", {31'b0, busy}, 32'h1);
  endtask

  task automatic end_txn();
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_oe", {28'b0, doe}, 32'h0);
    chk("idle_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[7:4], 1'b0, 4'h0);
    nib(b[3:0], 1'b0, 4'h0);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int k = 5; k >= 0; k--) nib(a[k*4 +: 4], 1'b0, 4'h0);
  endtask

  task automatic write_txn(input logic [23:0] a, input bq_t q,
                           input bit has_trail, input logic [3:0] trail);
    logic [15:0] ma;
    start_txn();
    send_byte(8'h38);
    send_addr(a);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      ma = a[15:0] + 16'(i);
      m_mem[ma] = q[i];
    end
    if (has_trail) nib(trail, 1'b0, 4'h0);
    end_txn();
  endtask

  task automatic read_head(input logic [23:0] a);
    start_txn();
    send_byte(8'hEB);
    send_addr(a);
    for (int k = 0; k < 4; k++) nib(4'h0, 1'b0, 4'h0);
  endtask

  task automatic read_txn(input logic [23:0] a, input int n);
    logic [15:0] ma;
    logic [7:0]  b;
    logic [3:0]  hi;
    got.delete();
    read_head(a);
    for (int i = 0; i < n; i++) begin
      ma = a[15:0] + 16'(i);
      b  = m_mem[ma];
      nib(4'h0, 1'b1, b[7:4]);
      hi = cap_nib;
      nib(4'h0, 1'b1, b[3:0]);
      got.push_back({hi, cap_nib});
    end
    end_txn();
  endtask

  initial begin
    // reset held: outputs quiet regardless of bus activity
    for (int i = 0; i < 12; i++) begin
      sck  = i[0];
      cs_n = i[1];
      sd   = 4'(i);
      @(negedge clk);
      chk("rst_oe", {28'b0, doe}, 32'h0);
      chk("rst_out", {28'b0, dout}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
    end
    sck = 1'b0; cs_n = 1'b1; sd = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // write then read back
    wq = {8'hA5, 8'h3C, 8'h0F};
    write_txn(24'h000010, wq, 1'b0, 4'h0);
    read_txn(24'h000010, 3);
    chk("wr_rd_b0", {24'b0, got[0]}, 32'hA5);
    chk("wr_rd_b1", {24'b0, got[1]}, 32'h3C);
    chk("wr_rd_b2", {24'b0, got[2]}, 32'h0F);

    // address wrap at the top of the array
    wq = {8'h11, 8'h22};
    write_txn(24'h00FFFF, wq, 1'b0, 4'h0);
    read_txn(24'h00FFFF, 2);
    chk("wrap_b0", {24'b0, got[0]}, 32'h11);
    chk("wrap_b1", {24'b0, got[1]}, 32'h22);
    read_txn(24'h000000, 1);
    chk("wrap_zero", {24'b0, got[0]}, 32'h22);

    // write aborted after a lone high nibble leaves the byte unchanged
    wq = {8'h77};
    write_txn(24'h000020, wq, 1'b0, 4'h0);
    wq.delete();
    write_txn(24'h000020, wq, 1'b1, 4'h5);
    read_txn(24'h000020, 1);
    chk("abort_wr", {24'b0, got[0]}, 32'h77);

    // read aborted mid-byte: oe drops within 3 clk, next transaction decodes normally
    read_head(24'h000010);
    nib(4'h0, 1'b1, m_mem[16'h0010][7:4]);
    nib(4'h0, 1'b1, m_mem[16'h0010][3:0]);
    nib(4'h0, 1'b1, m_mem[16'h0011][7:4]);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_rd_oe", {28'b0, doe}, 32'h0);
    repeat (3) @(negedge clk);
    read_txn(24'h000011, 1);
    chk("after_abort", {24'b0, got[0]}, 32'h3C);

    // unknown command: no drive, and a write-shaped payload must not land
    start_txn();
    send_byte(8'h9F);
    send_addr(24'h000010);
    send_byte(8'h55);
    end_txn();
    read_txn(24'h000010, 1);
    chk("bad_cmd", {24'b0, got[0]}, 32'hA5);

    // minimum bus phases, upper address bits aliased away
    H = 3; L = 3;
    read_txn(24'hFF0010, 2);
    chk("alias_b0", {24'b0, got[0]}, 32'hA5);
    chk("alias_b1", {24'b0, got[1]}, 32'h3C);
    H = 4; L = 4;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
